// File: rtl/csr_pkg.sv
// Shared types for the machine-mode trap sequencer: FSM states, CSR
// command ops, interrupt cause codes and the atomic trap command bundle.
package csr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_UPDATE   = 2'd2,
        ST_REDIRECT = 2'd3
    } trap_state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_TRAP = 2'd1,
        OP_MRET = 2'd2
    } trap_op_t;

    localparam logic [3:0] IRQ_MSI = 4'd3;
    localparam logic [3:0] IRQ_MTI = 4'd7;
    localparam logic [3:0] IRQ_MEI = 4'd11;

    typedef struct packed {
        trap_op_t    op;
        logic [63:0] mepc;
        logic [63:0] mcause;
        logic [63:0] mtval;
    } trap_cmd_t;

endpackage

// File: rtl/irq_arbiter.sv
// Fixed-priority machine interrupt arbiter: MEI over MSI over MTI,
// gated by the global mstatus.MIE enable.
module irq_arbiter
    import csr_pkg::*;
(
    input  logic [63:0] mie,
    input  logic [63:0] mip,
    input  logic        mstatus_mie,
    output logic        irq_valid,
    output logic [3:0]  irq_code
);

    logic [63:0] pend;
    logic        unused_pend;

    assign pend        = mie & mip;
    // Only the three machine-level sources are implemented.
    assign unused_pend = ^{pend[63:12], pend[10:8], pend[6:4], pend[2:0]};

    // Pick the highest-priority enabled and pending source.
    always_comb begin
        irq_valid = 1'b0;
        irq_code  = 4'd0;
        if (mstatus_mie) begin
            if (pend[IRQ_MEI]) begin
                irq_valid = 1'b1;
                irq_code  = IRQ_MEI;
            end else if (pend[IRQ_MSI]) begin
                irq_valid = 1'b1;
                irq_code  = IRQ_MSI;
            end else if (pend[IRQ_MTI]) begin
                irq_valid = 1'b1;
                irq_code  = IRQ_MTI;
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer beside writeback: on an interrupt, exception or mret at
// commit it kills the commit, drains the pipe, issues one atomic CSR
// command and redirects fetch.
// Build option: TRAP_VECTORED_EN enables vectored interrupt targets
// (mtvec mode 1: base + 4*code); without it the target is always base.
module trap_ctrl
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        commit_valid_i,
    input  logic [63:0] commit_pc_i,
    input  logic        exc_valid_i,
    input  logic [3:0]  exc_code_i,
    input  logic [63:0] exc_tval_i,
    input  logic        is_mret_i,
    input  logic        mstatus_mie_i,
    input  logic [63:0] mie_i,
    input  logic [63:0] mip_i,
    input  logic [63:0] mtvec_i,
    input  logic [63:0] mepc_i,
    input  logic        mem_busy_i,
    input  logic        redirect_ready_i,
    output logic        commit_kill_o,
    output logic        flush_o,
    output logic        csr_we_o,
    output logic [1:0]  csr_op_o,
    output logic [63:0] csr_mepc_o,
    output logic [63:0] csr_mcause_o,
    output logic [63:0] csr_mtval_o,
    output logic        redirect_valid_o,
    output logic [63:0] redirect_pc_o,
    output logic        busy_o
);

    trap_state_t state_q, state_d;
    trap_cmd_t   cmd_q, cmd_d;
    logic [63:0] target_q, target_d;
    logic        irq_valid;
    logic [3:0]  irq_code;
    logic        event_hit;

    irq_arbiter u_irq_arbiter (
        .mie         (mie_i),
        .mip         (mip_i),
        .mstatus_mie (mstatus_mie_i),
        .irq_valid   (irq_valid),
        .irq_code    (irq_code)
    );

    assign event_hit = commit_valid_i & (irq_valid | exc_valid_i | is_mret_i);

    // Build the command for the current commit: interrupt beats exception
    // beats mret. An interrupt reports mepc = this PC so it re-executes.
    always_comb begin
        cmd_d = '0;
        if (irq_valid) begin
            cmd_d.op     = OP_TRAP;
            cmd_d.mepc   = commit_pc_i;
            cmd_d.mcause = {1'b1, 59'd0, irq_code};
        end else if (exc_valid_i) begin
            cmd_d.op     = OP_TRAP;
            cmd_d.mepc   = commit_pc_i;
            cmd_d.mcause = {60'd0, exc_code_i};
            cmd_d.mtval  = exc_tval_i;
        end else begin
            cmd_d.op     = OP_MRET;
        end
    end

    // Redirect target, evaluated from the live mtvec/mepc during UPDATE.
    // The interrupt flag and code come back out of the latched mcause.
`ifdef TRAP_VECTORED_EN
    always_comb begin
        target_d = {mtvec_i[63:2], 2'b00};
        if (cmd_q.op == OP_MRET)
            target_d = mepc_i;
        else if (mtvec_i[1:0] == 2'b01 && cmd_q.mcause[63])
            target_d = {mtvec_i[63:2], 2'b00} + {58'd0, cmd_q.mcause[3:0], 2'b00};
    end
`else
    logic unused_mode;
    assign unused_mode = ^mtvec_i[1:0];

    always_comb begin
        target_d = {mtvec_i[63:2], 2'b00};
        if (cmd_q.op == OP_MRET)
            target_d = mepc_i;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state and per-state strobes. Outside IDLE every commit is
    // killed and nothing new is captured.
    always_comb begin
        state_d          = state_q;
        commit_kill_o    = 1'b0;
        flush_o          = 1'b0;
        csr_we_o         = 1'b0;
        redirect_valid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                commit_kill_o = event_hit;
                if (event_hit) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                commit_kill_o = commit_valid_i;
                flush_o       = 1'b1;
                if (!mem_busy_i) state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                commit_kill_o = commit_valid_i;
                flush_o       = 1'b1;
                csr_we_o      = 1'b1;
                state_d       = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                commit_kill_o    = commit_valid_i;
                redirect_valid_o = 1'b1;
                if (redirect_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command and target latches; cleared once the redirect is taken so
    // the CSR outputs read zero while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q    <= '0;
            target_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE:     if (event_hit) cmd_q <= cmd_d;
                ST_UPDATE:   target_q <= target_d;
                ST_REDIRECT: if (redirect_ready_i) begin
                    cmd_q    <= '0;
                    target_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign csr_op_o      = cmd_q.op;
    assign csr_mepc_o    = cmd_q.mepc;
    assign csr_mcause_o  = cmd_q.mcause;
    assign csr_mtval_o   = cmd_q.mtval;
    assign redirect_pc_o = target_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: exception, interrupts, priority, mret,
// backpressure, reset mid-sequence and mtvec vectored mode.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic        exc_valid;
    logic [3:0]  exc_code;
    logic [63:0] exc_tval;
    logic        is_mret;
    logic        mstatus_mie;
    logic [63:0] mie, mip, mtvec, mepc;
    logic        mem_busy;
    logic        redirect_ready;
    logic        commit_kill, flush, csr_we;
    logic [1:0]  csr_op;
    logic [63:0] csr_mepc, csr_mcause, csr_mtval;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int we_cnt  = 0;
    int we0;
    logic [63:0] vec_exp;

    always #5 clk = ~clk;

    always @(posedge clk) if (csr_we) we_cnt++;

    trap_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .commit_valid_i   (commit_valid),
        .commit_pc_i      (commit_pc),
        .exc_valid_i      (exc_valid),
        .exc_code_i       (exc_code),
        .exc_tval_i       (exc_tval),
        .is_mret_i        (is_mret),
        .mstatus_mie_i    (mstatus_mie),
        .mie_i            (mie),
        .mip_i            (mip),
        .mtvec_i          (mtvec),
        .mepc_i           (mepc),
        .mem_busy_i       (mem_busy),
        .redirect_ready_i (redirect_ready),
        .commit_kill_o    (commit_kill),
        .flush_o          (flush),
        .csr_we_o         (csr_we),
        .csr_op_o         (csr_op),
        .csr_mepc_o       (csr_mepc),
        .csr_mcause_o     (csr_mcause),
        .csr_mtval_o      (csr_mtval),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc),
        .busy_o           (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Caller drives the event at a negedge (cycle T); this walks T..T+4
    // with no backpressure.
    task automatic run_event(input string tag, input logic [63:0] e_op,
                             input logic [63:0] e_mepc, input logic [63:0] e_mcause,
                             input logic [63:0] e_mtval, input logic [63:0] e_pc);
        #1;
        chk({tag, ".kill"}, commit_kill, 1);
        @(negedge clk);
        commit_valid = 0; exc_valid = 0; is_mret = 0;
        #1;
        chk({tag, ".drain_flush"}, flush, 1);
        chk({tag, ".drain_we"}, csr_we, 0);
        @(negedge clk); #1;
        chk({tag, ".we"}, csr_we, 1);
        chk({tag, ".op"}, csr_op, e_op);
        chk({tag, ".mepc"}, csr_mepc, e_mepc);
        chk({tag, ".mcause"}, csr_mcause, e_mcause);
        chk({tag, ".mtval"}, csr_mtval, e_mtval);
        @(negedge clk); #1;
        chk({tag, ".rvalid"}, redirect_valid, 1);
        chk({tag, ".rpc"}, redirect_pc, e_pc);
        @(negedge clk); #1;
        chk({tag, ".idle"}, busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; commit_valid = 0; commit_pc = 0; exc_valid = 0; exc_code = 0;
        exc_tval = 0; is_mret = 0; mstatus_mie = 0; mie = 0; mip = 0;
        mtvec = 64'h8000_1000; mepc = 0; mem_busy = 0; redirect_ready = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.kill", commit_kill, 0);
        chk("rst.flush", flush, 0);
        chk("rst.we", csr_we, 0);
        chk("rst.op", csr_op, 0);
        chk("rst.mcause", csr_mcause, 0);
        chk("rst.rvalid", redirect_valid, 0);
        chk("rst.rpc", redirect_pc, 0);
        chk("rst.busy", busy, 0);
        reset = 0;

        // Exception, ecall-from-M style
        @(negedge clk);
        commit_pc = 64'h8000_0010; exc_valid = 1; exc_code = 4'd11; exc_tval = 0; commit_valid = 1;
        run_event("exc", 1, 64'h8000_0010, 64'd11, 0, 64'h8000_1000);

        // Exception carrying a tval
        @(negedge clk);
        commit_pc = 64'h8000_0020; exc_valid = 1; exc_code = 4'd2; exc_tval = 64'hDEAD_BEEF; commit_valid = 1;
        run_event("exc_tval", 1, 64'h8000_0020, 64'd2, 64'hDEAD_BEEF, 64'h8000_1000);

        // Timer interrupt
        @(negedge clk);
        mie = 64'h80; mip = 64'h80; mstatus_mie = 1; commit_pc = 64'h8000_0100; commit_valid = 1;
        run_event("mti", 1, 64'h8000_0100, 64'h8000_0000_0000_0007, 0, 64'h8000_1000);

        // Same pending timer but global MIE clear: nothing happens
        @(negedge clk);
        mstatus_mie = 0; commit_valid = 1;
        #1;
        chk("mie0.kill", commit_kill, 0);
        @(negedge clk);
        commit_valid = 0;
        #1;
        chk("mie0.busy", busy, 0);

        // All three pending plus an exception: MEI wins
        @(negedge clk);
        mie = 64'h888; mip = 64'h888; mstatus_mie = 1; exc_valid = 1; exc_code = 4'd5;
        exc_tval = 64'h1234; commit_pc = 64'h8000_0200; commit_valid = 1;
        run_event("prio_mei", 1, 64'h8000_0200, 64'h8000_0000_0000_000B, 0, 64'h8000_1000);

        // Drop MEIP: MSI next
        @(negedge clk);
        mip = 64'h088; exc_valid = 1; commit_valid = 1;
        run_event("prio_msi", 1, 64'h8000_0200, 64'h8000_0000_0000_0003, 0, 64'h8000_1000);

        // mret
        @(negedge clk);
        mstatus_mie = 0; mie = 0; mip = 0; mepc = 64'h8000_0204; is_mret = 1; commit_valid = 1;
        run_event("mret", 2, 0, 0, 0, 64'h8000_0204);

        // Backpressure: mem_busy for 5 cycles, then redirect_ready low 2 cycles
        we0 = we_cnt;
        @(negedge clk);
        commit_pc = 64'h8000_0300; exc_valid = 1; exc_code = 4'd4; exc_tval = 64'h40; commit_valid = 1;
        #1;
        chk("bp.kill", commit_kill, 1);
        @(negedge clk);
        commit_valid = 0; exc_valid = 0; mem_busy = 1;
        #1;
        chk("bp.we_t1", csr_we, 0);
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            if (k == 6) mem_busy = 0;
            if (k == 3) begin commit_valid = 1; exc_valid = 1; exc_code = 4'd7; end
            if (k == 4) begin commit_valid = 0; exc_valid = 0; end
            #1;
            chk($sformatf("bp.we_t%0d", k), csr_we, 0);
            chk($sformatf("bp.flush_t%0d", k), flush, 1);
            if (k == 3) chk("bp.kill_busy", commit_kill, 1);
        end
        @(negedge clk);
        redirect_ready = 0;
        #1;
        chk("bp.we_t7", csr_we, 1);
        chk("bp.mcause", csr_mcause, 64'd4);
        chk("bp.mtval", csr_mtval, 64'h40);
        for (int k = 8; k <= 10; k++) begin
            @(negedge clk);
            if (k == 10) redirect_ready = 1;
            #1;
            chk($sformatf("bp.rvalid_t%0d", k), redirect_valid, 1);
            chk($sformatf("bp.rpc_t%0d", k), redirect_pc, 64'h8000_1000);
            chk($sformatf("bp.mcause_t%0d", k), csr_mcause, 64'd4);
        end
        @(negedge clk); #1;
        chk("bp.idle", busy, 0);
        chk("bp.we_count", we_cnt - we0, 1);

        // Reset while in DRAIN
        we0 = we_cnt;
        @(negedge clk);
        commit_pc = 64'h8000_0310; exc_valid = 1; exc_code = 4'd6; commit_valid = 1;
        @(negedge clk);
        commit_valid = 0; exc_valid = 0; reset = 1;
        #1;
        chk("rstd.flush_pre", flush, 1);
        @(negedge clk); #1;
        chk("rstd.flush", flush, 0);
        chk("rstd.we", csr_we, 0);
        chk("rstd.rvalid", redirect_valid, 0);
        chk("rstd.busy", busy, 0);
        chk("rstd.op", csr_op, 0);
        chk("rstd.mcause", csr_mcause, 0);
        reset = 0;
        repeat (3) @(negedge clk);
        chk("rstd.we_count", we_cnt - we0, 0);

        // Vectored mtvec with a timer interrupt
`ifdef TRAP_VECTORED_EN
        vec_exp = 64'h8000_101C;
`else
        vec_exp = 64'h8000_1000;
`endif
        @(negedge clk);
        mtvec = 64'h8000_1001; mie = 64'h80; mip = 64'h80; mstatus_mie = 1;
        commit_pc = 64'h8000_0400; commit_valid = 1;
        run_event("vec_mti", 1, 64'h8000_0400, 64'h8000_0000_0000_0007, 0, vec_exp);

        // Exceptions ignore vectored mode
        @(negedge clk);
        mstatus_mie = 0; exc_valid = 1; exc_code = 4'd2; exc_tval = 0;
        commit_pc = 64'h8000_0410; commit_valid = 1;
        run_event("vec_exc", 1, 64'h8000_0410, 64'd2, 0, 64'h8000_1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
